// File: rtl/div_if.sv
// Execute-stage divider handshake: operands and control from the pipeline,
// stall/done/result back to it.
interface div_if #(
   parameter int WIDTH = 32
);
   logic             div_start;
   logic             div_en;
   logic [1:0]       div_ctrl;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cache_stall;
   logic             div_stall;
   logic             div_done;
   logic [WIDTH-1:0] div_result;

   modport master (
      output div_start, div_en, div_ctrl, op_a, op_b, cache_stall,
      input  div_stall, div_done, div_result
   );

   modport slave (
      input  div_start, div_en, div_ctrl, op_a, op_b, cache_stall,
      output div_stall, div_done, div_result
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are fixed up when the
// result register is loaded on entry to DONE.
module div_unit #(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic rst_n,
   div_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       ctrl_q;
   logic             neg_q, neg_r;
   logic [WIDTH-1:0] dq, rem, dvs, res;
   logic [CW-1:0]    cnt;
   logic             stall, done, load_res;

   // operand decode for the start cycle
   logic             sgn, sa, sb, div_zero, ovf, special;
   logic [WIDTH-1:0] abs_a, abs_b, special_res;

   assign sgn      = ~bus.div_ctrl[0];
   assign sa       = sgn & bus.op_a[WIDTH-1];
   assign sb       = sgn & bus.op_b[WIDTH-1];
   assign abs_a    = sa ? -bus.op_a : bus.op_a;
   assign abs_b    = sb ? -bus.op_b : bus.op_b;
   assign div_zero = (bus.op_b == '0);
   assign ovf      = sgn && (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.op_b);
   assign special  = div_zero | ovf;

   // special results: quotient all-ones / remainder op_a on /0, MIN / 0 on overflow
   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = bus.div_ctrl[1] ? bus.op_a : '1;
      else if (!bus.div_ctrl[1])
         special_res = {1'b1, {(WIDTH-1){1'b0}}};
   end

   // one restoring step; the bit shifted out of rem is kept so that divisors
   // with the top bit set still compare correctly
   logic [WIDTH:0]   shifted, diff;
   logic             ge;
   logic [WIDTH-1:0] dq_n, rem_n, q_fix, r_fix;

   assign shifted = {rem, dq[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};
   assign ge      = shifted[WIDTH] | ~diff[WIDTH];
   assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign dq_n    = {dq[WIDTH-2:0], ge};
   assign q_fix   = neg_q ? -dq_n : dq_n;
   assign r_fix   = neg_r ? -rem_n : rem_n;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state and handshake outputs
   always_comb begin
      state_d  = state_q;
      stall    = 1'b0;
      done     = 1'b0;
      load_res = 1'b0;
      case (state_q)
         IDLE: if (bus.div_start) begin
            stall   = 1'b1;
            state_d = special ? DONE : CALC;
         end
         CALC: begin
            stall = 1'b1;
            if (!bus.div_en) state_d = IDLE;
            else if (cnt == '0) begin
               state_d  = DONE;
               load_res = 1'b1;
            end
         end
         DONE: begin
            done = bus.div_en;
            if (!bus.div_en || !bus.cache_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // datapath: latch on start, iterate in CALC, load result on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dq     <= '0;
         rem    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         res    <= '0;
      end else if (state_q == IDLE && bus.div_start) begin
         ctrl_q <= bus.div_ctrl;
         neg_q  <= sa ^ sb;
         neg_r  <= sa;
         dq     <= abs_a;
         dvs    <= abs_b;
         rem    <= '0;
         cnt    <= CW'(WIDTH-1);
         if (special) res <= special_res;
      end else if (state_q == CALC) begin
         dq  <= dq_n;
         rem <= rem_n;
         cnt <= cnt - 1'b1;
         if (load_res) res <= ctrl_q[1] ? r_fix : q_fix;
      end
   end

   assign bus.div_stall  = stall;
   assign bus.div_done   = done;
   assign bus.div_result = res;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, stall/done timing, special cases,
// cache_stall hold, flush and mid-operation reset.
module tb_div_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   div_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one divide and follow it through to IDLE.
   task automatic run_div(input string tag, input logic [1:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_stalls, input int cs_cycles);
      int stalls = 0;
      int cyc = 0;
      int dn = 0;
      @(negedge clk);
      bus.div_ctrl    = c;
      bus.op_a        = a;
      bus.op_b        = b;
      bus.div_start   = 1'b1;
      bus.div_en      = 1'b1;
      bus.cache_stall = 1'b0;
      #1;
      while (!bus.div_done && cyc < 100) begin
         if (bus.div_stall) stalls++;
         @(negedge clk);
         bus.div_start = 1'b0;
         bus.op_a      = 32'hA5A5_5A5A;  // operands must have been latched
         bus.op_b      = 32'h0000_0003;
         #1;
         cyc++;
      end
      chk({tag, " done_seen"}, 32'(bus.div_done), 32'd1);
      chk({tag, " stall_cycles"}, stalls, exp_stalls);
      chk({tag, " done_cycle"}, cyc, exp_stalls);
      while (bus.div_done && dn < 20) begin
         dn++;
         chk({tag, " result"}, bus.div_result, exp_res);
         chk({tag, " stall_in_done"}, 32'(bus.div_stall), 32'd0);
         bus.cache_stall = (dn <= cs_cycles);
         @(negedge clk);
         #1;
      end
      chk({tag, " done_cycles"}, dn, cs_cycles + 1);
      bus.cache_stall = 1'b0;
      bus.div_en      = 1'b0;
      chk({tag, " idle_stall"}, 32'(bus.div_stall), 32'd0);
   endtask

   initial begin
      int dcount;
      bus.div_start   = 1'b0;
      bus.div_en      = 1'b0;
      bus.div_ctrl    = 2'b00;
      bus.op_a        = '0;
      bus.op_b        = '0;
      bus.cache_stall = 1'b0;

      // reset state
      #12;
      chk("rst stall", 32'(bus.div_stall), 32'd0);
      chk("rst done", 32'(bus.div_done), 32'd0);
      chk("rst result", bus.div_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // normal operations: 33 stall cycles
      run_div("div_100_7",   2'b00, 32'd100,       32'd7, 32'd14,        33, 0);
      run_div("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
      run_div("divu_fff9_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
      run_div("remu_fff9_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1,         33, 0);
      run_div("div_m100_7",  2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0);
      run_div("rem_m100_7",  2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 0);
      run_div("divu_bigdiv", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 0);
      run_div("remu_bigdiv", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0);

      // special cases: single stall cycle
      run_div("divu_by0", 2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_div("rem_by0",  2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
      run_div("div_ovf",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_div("rem_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

      // cache_stall holds DONE for 4 extra cycles
      run_div("div_50_5_cs", 2'b00, 32'd50, 32'd5, 32'd10, 33, 4);

      // flush mid-CALC: no done, result register untouched
      @(negedge clk);
      bus.div_ctrl  = 2'b00;
      bus.op_a      = 32'd100;
      bus.op_b      = 32'd7;
      bus.div_start = 1'b1;
      bus.div_en    = 1'b1;
      @(negedge clk);
      bus.div_start = 1'b0;
      repeat (4) @(negedge clk);
      bus.div_en = 1'b0;
      @(negedge clk);
      #1;
      chk("flush stall", 32'(bus.div_stall), 32'd0);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (bus.div_done) dcount++;
      end
      chk("flush no_done", dcount, 0);
      chk("flush result_kept", bus.div_result, 32'd10);

      // reset in CALC cycle 10
      @(negedge clk);
      bus.div_ctrl  = 2'b00;
      bus.op_a      = 32'd1000;
      bus.op_b      = 32'd3;
      bus.div_start = 1'b1;
      bus.div_en    = 1'b1;
      @(negedge clk);
      bus.div_start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst stall", 32'(bus.div_stall), 32'd0);
      chk("midrst done", 32'(bus.div_done), 32'd0);
      chk("midrst result", bus.div_result, 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      bus.div_en = 1'b0;
      #1;
      chk("postrst stall", 32'(bus.div_stall), 32'd0);
      run_div("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, located in the EXECUTE stage next to the ALU and multiplier. It latches its operands on the one-cycle start pulse that the decode/execute register emits when a divide enters EX. While it computes, it holds the front of the pipeline through `div_stall`. It then presents a stable result until the pipeline takes it.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `div_start`  in  1  one-cycle start pulse (from `div_start_e`)
- `div_en`  in  1  divide instruction currently in EX (from `div_en_e`)
- `div_ctrl`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `op_a`  in  WIDTH  dividend (forwarded rs1 value)
- `op_b`  in  WIDTH  divisor (forwarded rs2 value)
- `cache_stall`  in  1  memory-side freeze; result must be held while high
- `div_stall`  out  1  freeze F/D/DE registers; divide not yet finished
- `div_done`  out  1  `div_result` valid this cycle
- `div_result`  out  WIDTH  quotient or remainder, per the latched `div_ctrl`

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - On `div_start`=1: latch `div_ctrl` and sign flags.
  - Latch |`op_a`| and |`op_b`| for signed ops, or raw values for unsigned ops.
  - Clear the remainder accumulator and set the iteration counter to `WIDTH`-1.
  - If `op_b`=0, or a signed op has `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: load the special result and go to DONE.
  - Otherwise go to CALC.
  - `div_start` is ignored in CALC and DONE.
- **CALC**
  - One restoring step per cycle: rem = {rem[W-2:0], dq[W-1]}; dq <<= 1.
  - If rem ≥ divisor: rem −= divisor and dq[0] = 1.
  - The subtract uses W+1 bits; the borrow selects restore.
  - The counter decrements each step; after the step with counter = 0, go to DONE.
- **DONE**: `div_result` is driven from the result register.
  - Signed quotient is negated if the dividend and divisor signs differ.
  - Signed remainder takes the sign of the dividend.
  - Go to IDLE when `cache_stall`=0. Stay in DONE while `cache_stall`=1, with the result held.
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF (all ops); remainder = `op_a`.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- `div_stall` = (IDLE & `div_start`) | CALC. It is combinational and is low in DONE.
- `div_done` = DONE.
- Reset (`rst_n`=0, any state including mid-CALC): state = IDLE, all datapath registers = 0, `div_stall`=0, `div_done`=0, `div_result`=0. The operation in progress is discarded with no residual effect.
- If `div_en`=0 while in CALC or DONE, the EX slot has been flushed. Return to IDLE next cycle and do not assert `div_done`.

## Timing
- Cycle 0: `div_start` sampled high; `div_stall`=1 in the same cycle.
- Normal case:
  - Cycles 1..WIDTH: CALC, `div_stall`=1.
  - Cycle WIDTH+1: DONE, `div_stall`=0, `div_done`=1. The pipeline advances at the end of this cycle.
  - Total `div_stall` cycles = WIDTH+1 (33).
- Special case: cycle 1 is DONE; total `div_stall` cycles = 1.
- `div_result` is registered and only changes on the transition into DONE. It stays stable in DONE regardless of `op_a`/`op_b`.
- `cache_stall` high in DONE extends DONE one cycle per stalled cycle. `div_stall` stays 0 throughout; `div_done` stays 1.
- A back-to-back divide is accepted in the IDLE cycle immediately after DONE.

## Test plan
- DIV 100 / 7 → `div_result`=14. `div_stall` high for exactly 33 cycles; `div_done` pulses in cycle 33.
- REM −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. REMU 0xFFFFFFF9 / 2 → 1.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF after 1 stall cycle. REM 0x12345678 / 0 → 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, 1 stall cycle. REM with the same operands → 0.
- DIV 50 / 5 with `cache_stall`=1 for 4 cycles on reaching DONE → `div_result`=10 held and `div_done`=1 for 5 cycles, then IDLE.
- Start DIV, drop `rst_n` at CALC cycle 10 for 1 cycle → all outputs 0, state IDLE. A new DIVU 9 / 3 then returns 3 after 33 stall cycles.
